mem_arbiter: RTL and testbench

- Sole owner of the byte-wide external RAM/IO port.
- Sequences multi-byte loads and stores from the load/store buffer, and 32-bit instruction fetches, into byte-serial memory cycles.
- Arbitrates between the two requesters, assembles or splits data, and signals completion with one-cycle success pulses.
- Sits between the LSB / instruction fetcher and the top-level memory pins.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_byte_assembler.sv | 41 ++++
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the byte-serial memory arbiter
package mem_arbiter_pkg;

  localparam logic [1:0]  REQ8            = 2'd0;
  localparam logic [1:0]  REQ16           = 2'd1;
  localparam logic [1:0]  REQ32           = 2'd2;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LOAD,
    OWN_STORE,
    OWN_FETCH
  } owner_t;

endpackage

// File: rtl/mem_byte_assembler.sv
// rtl/mem_byte_assembler.sv - byte insert into a 32-bit capture word, store byte select, length decode
module mem_byte_assembler
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        cap_en,
  input  logic [1:0]  idx,
  input  logic [7:0]  din,
  input  logic [31:0] wdata,
  input  logic [1:0]  len,
  output logic [1:0]  last_idx,
  output logic [7:0]  wr_byte,
  output logic [31:0] word
);

  always_comb begin
    last_idx = 2'd3;
    if (len == REQ8)
      last_idx = 2'd0;
    else if (len == REQ16)
      last_idx = 2'd1;
  end

  assign wr_byte = wdata[{idx, 3'b000} +: 8];

  // Cleared while idle so short loads come out zero-extended
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      word <= '0;
    else if (rdy) begin
      if (clear)
        word <= '0;
      else if (cap_en)
        word[{idx, 3'b000} +: 8] <= din;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM/IO port owner for LSB loads/stores and instruction fetch
// Optional: define ROUND_ROBIN_EN to alternate priority between LSB and fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_read_signal,
  input  logic              lsb_write_signal,
  input  logic [1:0]        requiring_length,
  input  logic [ADDR_W-1:0] to_mem_addr,
  input  logic [31:0]       to_mem_data,
  output logic              mem_load_success,
  output logic              mem_store_success,
  output logic [31:0]       from_mem_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  state_t            state;
  owner_t            owner;
  logic [ADDR_W-1:0] base;
  logic [1:0]        len;
  logic [31:0]       wdata;
  logic [1:0]        cnt;
  logic [1:0]        issue_off;
  logic              primed;
  logic              fin;
  logic [1:0]        last_idx;
  logic [7:0]        wr_byte;
  logic [31:0]       word;
  logic              lsb_req;
  logic              pick_lsb;
  logic              is_io;
  logic              asm_clear;
  logic              asm_cap;

  assign lsb_req = lsb_read_signal | lsb_write_signal;
  assign is_io   = (base >= IO_BASE);

`ifdef ROUND_ROBIN_EN
  logic last_is_fetch;
  assign pick_lsb = lsb_req && (!if_req || last_is_fetch);
`else
  assign pick_lsb = lsb_req;
`endif

  // Reads see mem_din one cycle behind mem_a, hence the primed gate
  assign asm_clear = (state == ST_IDLE);
  assign asm_cap   = (state == ST_READ) && primed && !fin && !jump_wrong;

  mem_byte_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .clear    (asm_clear),
    .cap_en   (asm_cap),
    .idx      (cnt),
    .din      (mem_din),
    .wdata    (wdata),
    .len      (len),
    .last_idx (last_idx),
    .wr_byte  (wr_byte),
    .word     (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      owner             <= OWN_NONE;
      base              <= '0;
      len               <= REQ8;
      wdata             <= '0;
      cnt               <= '0;
      issue_off         <= '0;
      primed            <= 1'b0;
      fin               <= 1'b0;
      if_done           <= 1'b0;
      if_data           <= '0;
      mem_load_success  <= 1'b0;
      mem_store_success <= 1'b0;
      from_mem_data     <= '0;
      mem_dout          <= '0;
      mem_a             <= '0;
      mem_wr            <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_is_fetch     <= 1'b1;
`endif
    end else if (rdy) begin
      if_done           <= 1'b0;
      mem_load_success  <= 1'b0;
      mem_store_success <= 1'b0;
      case (state)
        ST_IDLE: begin
          mem_a     <= '0;
          mem_wr    <= 1'b0;
          mem_dout  <= '0;
          cnt       <= '0;
          issue_off <= '0;
          primed    <= 1'b0;
          fin       <= 1'b0;
          if (!jump_wrong && (lsb_req || if_req)) begin
            if (pick_lsb) begin
              base  <= to_mem_addr;
              len   <= requiring_length;
              wdata <= to_mem_data;
              if (lsb_write_signal) begin
                owner <= OWN_STORE;
                state <= ST_WRITE;
              end else begin
                owner <= OWN_LOAD;
                state <= ST_READ;
                mem_a <= to_mem_addr;
              end
            end else begin
              base  <= if_addr;
              len   <= REQ32;
              owner <= OWN_FETCH;
              state <= ST_READ;
              mem_a <= if_addr;
            end
`ifdef ROUND_ROBIN_EN
            last_is_fetch <= !pick_lsb;
`endif
          end
        end
        ST_READ: begin
          if (jump_wrong) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
            mem_a <= '0;
          end else if (fin) begin
            state <= ST_DONE;
            if (owner == OWN_FETCH) begin
              if_done <= 1'b1;
              if_data <= word;
            end else begin
              mem_load_success <= 1'b1;
              from_mem_data    <= word;
            end
          end else begin
            primed <= 1'b1;
            if (issue_off != last_idx) begin
              issue_off <= issue_off + 2'd1;
              mem_a     <= mem_a + ADDR_W'(1);
            end else begin
              mem_a <= '0;
            end
            if (primed) begin
              if (cnt == last_idx)
                fin <= 1'b1;
              else
                cnt <= cnt + 2'd1;
            end
          end
        end
        ST_WRITE: begin
          // Stores are committed, so jump_wrong is deliberately ignored here
          if (fin) begin
            state             <= ST_DONE;
            mem_wr            <= 1'b0;
            mem_a             <= '0;
            mem_dout          <= '0;
            mem_store_success <= 1'b1;
          end else if (is_io && io_buffer_full) begin
            mem_wr <= 1'b0;
          end else begin
            mem_a    <= base + ADDR_W'(cnt);
            mem_dout <= wr_byte;
            mem_wr   <= 1'b1;
            if (cnt == last_idx)
              fin <= 1'b1;
            else
              cnt <= cnt + 2'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          owner <= OWN_NONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a byte RAM model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int K_LD = 0;
  localparam int K_ST = 1;
  localparam int K_IF = 2;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong, if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        lsb_read_signal, lsb_write_signal;
  logic [1:0]  requiring_length;
  logic [31:0] to_mem_addr, to_mem_data, from_mem_data;
  logic        mem_load_success, mem_store_success;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .jump_wrong        (jump_wrong),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_done           (if_done),
    .if_data           (if_data),
    .lsb_read_signal   (lsb_read_signal),
    .lsb_write_signal  (lsb_write_signal),
    .requiring_length  (requiring_length),
    .to_mem_addr       (to_mem_addr),
    .to_mem_data       (to_mem_data),
    .mem_load_success  (mem_load_success),
    .mem_store_success (mem_store_success),
    .from_mem_data     (from_mem_data),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full)
  );

  logic [7:0] ram [0:262143];
  int         wr_count = 0;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) begin
      ram[mem_a[17:0]] = mem_dout;
      wr_count++;
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] addr_seen [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_a"}, mem_a, 32'h0);
    chk({tag, "_flags"}, {27'd0, if_done, mem_load_success, mem_store_success, mem_wr, 1'b0}, 32'h0);
    chk({tag, "_dout"}, {24'd0, mem_dout}, 32'h0);
    chk({tag, "_if_data"}, if_data, 32'h0);
    chk({tag, "_ld_data"}, from_mem_data, 32'h0);
  endtask

  function automatic logic pulse_of(input int kind);
    if (kind == K_LD) return mem_load_success;
    if (kind == K_ST) return mem_store_success;
    return if_done;
  endfunction

  task automatic start_op(input int kind, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wd);
    @(negedge clk);
    if (kind == K_LD) begin
      lsb_read_signal = 1'b1; requiring_length = len; to_mem_addr = addr;
    end else if (kind == K_ST) begin
      lsb_write_signal = 1'b1; requiring_length = len; to_mem_addr = addr; to_mem_data = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
  endtask

  // Sample index c counts negedges after the acceptance edge (c = 0 right after it)
  task automatic finish_op(input int kind, input int c0, output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = '0;
    for (int c = c0; c < 40; c++) begin
      @(negedge clk);
      if (c < 8) addr_seen[c] = mem_a;
      if (pulse_of(kind)) begin
        lat = c;
        rd  = (kind == K_IF) ? if_data : from_mem_data;
        break;
      end
    end
    @(negedge clk);
    if (lat >= 0) chk("pulse_width", {31'd0, pulse_of(kind)}, 32'h0);
    lsb_read_signal = 1'b0; lsb_write_signal = 1'b0; if_req = 1'b0;
  endtask

  task automatic do_op(input int kind, input logic [1:0] len, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd);
    start_op(kind, len, addr, wd);
    finish_op(kind, 0, lat, rd);
  endtask

  typedef struct {
    int          kind;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vecs [0:10];

  initial begin
    int          lat, w0, ld_at, if_at, got, wr_hi;
    logic [31:0] rd;

    vecs[0]  = '{K_LD, REQ32, 32'h100, 32'h0,        32'h44332211, 6, 0};
    vecs[1]  = '{K_ST, REQ16, 32'h200, 32'hDEADBEEF, 32'h0,        3, 2};
    vecs[2]  = '{K_LD, REQ8,  32'h201, 32'h0,        32'h000000BE, 3, 0};
    vecs[3]  = '{K_LD, REQ16, 32'h200, 32'h0,        32'h0000BEEF, 4, 0};
    vecs[4]  = '{K_LD, REQ32, 32'h1FF, 32'h0,        32'h5ABEEF77, 6, 0};
    vecs[5]  = '{K_ST, REQ32, 32'h300, 32'hCAFEF00D, 32'h0,        5, 4};
    vecs[6]  = '{K_LD, REQ32, 32'h300, 32'h0,        32'hCAFEF00D, 6, 0};
    vecs[7]  = '{K_ST, REQ8,  32'h304, 32'h12345678, 32'h0,        2, 1};
    vecs[8]  = '{K_IF, REQ32, 32'h300, 32'h0,        32'hCAFEF00D, 6, 0};
    vecs[9]  = '{K_LD, REQ8,  32'h304, 32'h0,        32'h00000078, 3, 0};
    vecs[10] = '{K_IF, REQ8,  32'h101, 32'h0,        32'h00443322, 6, 0};

    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h44;
    ram[18'h1FF] = 8'h77; ram[18'h202] = 8'h5A;

    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; if_req = 1'b0; if_addr = '0;
    lsb_read_signal = 1'b0; lsb_write_signal = 1'b0; requiring_length = REQ8;
    to_mem_addr = '0; to_mem_data = '0; io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      w0 = wr_count;
      do_op(vecs[i].kind, vecs[i].len, vecs[i].addr, vecs[i].wd, lat, rd);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_writes", i), 32'(wr_count - w0), 32'(vecs[i].exp_wr));
      if (vecs[i].kind != K_ST) chk($sformatf("v%0d_data", i), rd, vecs[i].exp_d);
      if (i == 0)
        for (int k = 0; k < 4; k++)
          chk($sformatf("lw_addr%0d", k), addr_seen[k], 32'h100 + 32'(k));
    end
    chk("sh_byte_202_untouched", {24'd0, ram[18'h202]}, 32'h5A);

    // Simultaneous load and fetch, preceded by a load so the LSB owned last
    do_op(K_LD, REQ32, 32'h100, 32'h0, lat, rd);
    chk("pre_sim_data", rd, 32'h44332211);
    @(negedge clk);
    lsb_read_signal = 1'b1; requiring_length = REQ32; to_mem_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h300;
    ld_at = -1; if_at = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_load_success && ld_at < 0) begin ld_at = c; chk("sim_ld_data", from_mem_data, 32'h44332211); end
      if (if_done && if_at < 0) begin if_at = c; chk("sim_if_data", if_data, 32'hCAFEF00D); end
      if (ld_at >= 0 && c == ld_at + 1) lsb_read_signal = 1'b0;
      if (if_at >= 0 && c == if_at + 1) if_req = 1'b0;
      if (ld_at >= 0 && if_at >= 0 && c > ld_at && c > if_at) break;
    end
    lsb_read_signal = 1'b0; if_req = 1'b0;
`ifdef ROUND_ROBIN_EN
    chk("sim_if_latency", 32'(if_at), 32'd6);
    chk("sim_ld_latency", 32'(ld_at), 32'd14);
`else
    chk("sim_ld_latency", 32'(ld_at), 32'd6);
    chk("sim_if_latency", 32'(if_at), 32'd14);
`endif

    // Fetch flushed while its third byte address is on the bus
    start_op(K_IF, REQ32, 32'h100, 32'h0);
    repeat (3) @(negedge clk);
    chk("jw_fetch_byte2_addr", mem_a, 32'h102);
    jump_wrong = 1'b1; if_req = 1'b0;
    @(negedge clk);
    jump_wrong = 1'b0;
    chk("jw_fetch_bus_idle", mem_a, 32'h0);
    got = 0;
    repeat (10) begin
      @(negedge clk);
      if (if_done) got++;
    end
    chk("jw_fetch_no_done", 32'(got), 32'd0);

    // Store hit by jump_wrong still completes
    start_op(K_ST, REQ32, 32'h400, 32'h01020304);
    @(negedge clk);
    jump_wrong = 1'b1;
    @(negedge clk);
    jump_wrong = 1'b0;
    finish_op(K_ST, 2, lat, rd);
    chk("jw_store_latency", 32'(lat), 32'd5);
    chk("jw_store_ram", {ram[18'h403], ram[18'h402], ram[18'h401], ram[18'h400]}, 32'h01020304);

    // IO store stalled by a full UART buffer
    io_buffer_full = 1'b1;
    w0 = wr_count;
    start_op(K_ST, REQ8, 32'h30000, 32'h000000A5);
    wr_hi = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_wr) wr_hi++;
    end
    io_buffer_full = 1'b0;
    chk("io_stall_wr_low", 32'(wr_hi), 32'd0);
    @(negedge clk);
    chk("io_write_strobe", {31'd0, mem_wr}, 32'h1);
    chk("io_write_addr", mem_a, 32'h30000);
    chk("io_write_byte", {24'd0, mem_dout}, 32'hA5);
    finish_op(K_ST, 7, lat, rd);
    chk("io_store_latency", 32'(lat), 32'd7);
    chk("io_store_writes", 32'(wr_count - w0), 32'd1);
    chk("io_store_ram", {24'd0, ram[18'h30000]}, 32'hA5);

    // Asynchronous reset in the middle of a word load
    start_op(K_LD, REQ32, 32'h100, 32'h0);
    repeat (3) @(negedge clk);
    chk("pre_rst_addr", mem_a, 32'h102);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    lsb_read_signal = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(K_LD, REQ32, 32'h100, 32'h0, lat, rd);
    chk("post_rst_latency", 32'(lat), 32'd6);
    chk("post_rst_data", rd, 32'h44332211);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
